// File: rtl/rv32i_types.sv
// Shared types for the cache-side datapath: adaptor FSM state and burst geometry.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adaptor_state_t;

  localparam int BURST_BEATS = 4;
  localparam int BEAT_WIDTH  = 64;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache line port (pmem_*) and burst memory bus (bmem_*) seen by the adaptor.
// slave: the adaptor; master: the cache/memory environment around it.
interface cacheline_adaptor_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
) ();

  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  logic [31:0]       bmem_address;
  logic              bmem_read;
  logic              bmem_write;
  logic [s_beat-1:0] bmem_wdata;
  logic [s_beat-1:0] bmem_rdata;
  logic              bmem_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output bmem_address, bmem_read, bmem_write, bmem_wdata,
    input  bmem_rdata, bmem_resp
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  bmem_address, bmem_read, bmem_write, bmem_wdata,
    output bmem_rdata, bmem_resp
  );

endinterface

// File: rtl/line_beat_buffer.sv
// Line-wide staging register: whole-line load for writebacks, per-beat fill for
// refills, and a beat-select mux feeding the outgoing write beat.
module line_beat_buffer #(
  parameter int s_line  = 256,
  parameter int s_beat  = 64,
  parameter int n_beats = s_line / s_beat
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [s_line-1:0]          load_data,
  input  logic                       beat_we,
  input  logic [$clog2(n_beats)-1:0] beat_idx,
  input  logic [s_beat-1:0]          beat_wdata,
  output logic [s_beat-1:0]          beat_rdata,
  output logic [s_line-1:0]          line_data
);

  logic [n_beats-1:0][s_beat-1:0] beats_q;

  // Cleared on reset because the assembled line is visible on pmem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q <= '0;
    end else if (load_en) begin
      beats_q <= load_data;
    end else if (beat_we) begin
      beats_q[beat_idx] <= beat_wdata;
    end
  end

  assign beat_rdata = beats_q[beat_idx];
  assign line_data  = beats_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into a fixed 4-beat 64-bit memory burst.
// Optional macro CACHELINE_ALIGN_EN: clear the line-offset bits of bmem_address.
module cacheline_adaptor
  import rv32i_types::*;
#(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = BEAT_WIDTH,
  parameter int n_beats  = s_line / s_beat
) (
  input logic               clk,
  input logic               rst_n,
  cacheline_adaptor_if.slave bus
);

  localparam int CNT_W = $clog2(n_beats);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       addr_q;
  logic              accept_rd, accept_wr;
  logic              beat_done;
  logic              last_beat;
  logic [s_beat-1:0] wr_beat;
  logic [s_line-1:0] line_q;

  assign last_beat = (cnt_q == CNT_W'(n_beats - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write takes priority; a read still held is picked up on the next IDLE visit.
  always_comb begin
    state_d        = state_q;
    accept_rd      = 1'b0;
    accept_wr      = 1'b0;
    beat_done      = 1'b0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.pmem_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pmem_write) begin
          accept_wr = 1'b1;
          state_d   = WR_BURST;
        end else if (bus.pmem_read) begin
          accept_rd = 1'b1;
          state_d   = RD_BURST;
        end
      end
      RD_BURST: begin
        bus.bmem_read = 1'b1;
        if (bus.bmem_resp) begin
          beat_done = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        if (bus.bmem_resp) begin
          beat_done = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        bus.pmem_resp = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else if (accept_rd || accept_wr) begin
      cnt_q  <= '0;
`ifdef CACHELINE_ALIGN_EN
      addr_q <= {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
`else
      addr_q <= bus.pmem_address;
`endif
    end else if (beat_done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  line_beat_buffer #(
    .s_line  (s_line),
    .s_beat  (s_beat),
    .n_beats (n_beats)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (accept_wr),
    .load_data  (bus.pmem_wdata),
    .beat_we    (beat_done && (state_q == RD_BURST)),
    .beat_idx   (cnt_q),
    .beat_wdata (bus.bmem_rdata),
    .beat_rdata (wr_beat),
    .line_data  (line_q)
  );

  assign bus.bmem_address = addr_q;
  assign bus.bmem_wdata   = wr_beat;
  assign bus.pmem_rdata   = line_q;

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the L1 cache's 256-bit line port (`pmem_*`) to the 64-bit burst physical-memory bus. A line refill or writeback becomes a fixed 4-beat burst, and a completed burst becomes a single-cycle `pmem_resp` back to cache control. The block sits directly downstream of the cache, between it and main memory. It holds one request at a time.

## Interface
Parameters:
- `s_offset`, 5: line offset bits; line = 2**s_offset bytes.
- `s_line`, 256: line width in bits.
- `s_beat`, 64: burst beat width in bits.
- `n_beats`, `s_line/s_beat` (4): beats per burst.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pmem_address`  in  32  line address from the cache.
- `pmem_read`  in  1  line read request, held until `pmem_resp`.
- `pmem_write`  in  1  line write request, held until `pmem_resp`.
- `pmem_wdata`  in  256  writeback line; beat k = bits [64k+63:64k].
- `pmem_rdata`  out  256  assembled refill line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `bmem_address`  out  32  burst address.
- `bmem_read`  out  1  burst read request.
- `bmem_write`  out  1  burst write request.
- `bmem_wdata`  out  64  current write beat.
- `bmem_rdata`  in  64  current read beat.
- `bmem_resp`  in  1  beat accepted/valid strobe.

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - `pmem_write` → WR_BURST.
  - Else `pmem_read` → RD_BURST.
  - On acceptance, latch the address and, for a write, latch `pmem_wdata` into the line buffer.
  - If both requests are asserted together, the write wins and the read is served afterward if still held.
- RD_BURST:
  - `bmem_read`=1.
  - On each `bmem_resp`, store `bmem_rdata` into buffer beat[cnt], then cnt++.
  - On the resp with cnt=n_beats-1, go to DONE.
- WR_BURST:
  - `bmem_write`=1.
  - `bmem_wdata` = buffer beat[cnt].
  - Each `bmem_resp` advances cnt.
  - The last beat goes to DONE.
- DONE:
  - `pmem_resp`=1 for exactly this cycle, then return to IDLE.
  - Requests are not sampled in DONE. This prevents re-triggering while the cache drops its request.
- Beat counter:
  - `$clog2(n_beats)` bits wide; wraps to 0 after the last beat.
  - Cleared on entry to either burst state.
- `bmem_resp` is not required to be consecutive. Gap cycles hold cnt and outputs.
- `bmem_resp` in IDLE/DONE is ignored.
- `pmem_rdata` is driven from the buffer. It is valid in DONE and held until the next burst overwrites it.
- A change of `pmem_address` or `pmem_wdata` mid-burst has no effect, because the latched copies are used.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE, cnt=0.
  - `bmem_read`=`bmem_write`=`pmem_resp`=0.
  - `bmem_address`=0, `bmem_wdata`=0, `pmem_rdata`=0.
- Reset mid-burst aborts the burst: the strobes drop the following cycle and no `pmem_resp` is issued.
- All outputs are registered or decoded from registered state. There is no combinational path from any `pmem_*`/`bmem_*` input to an output.
- Latencies:
  - Request seen in IDLE at edge T → `bmem_read`/`bmem_write` high from T+1.
  - 4th `bmem_resp` at edge R → `pmem_resp` high in the cycle after R.
  - `bmem_read`/`bmem_write` go low in that same cycle.
  - Minimum request-to-resp latency: 6 cycles (1 accept + 4 beats + DONE).
- `bmem_address` is stable for the whole burst.

## Configuration
- `CACHELINE_ALIGN_EN`:
  - Defined: `bmem_address` = latched address with bits [s_offset-1:0] forced to 0.
  - Undefined: the latched address is passed through unmodified, and the cache is responsible for alignment.

## Structure
- Shared package `rv32i_types` gains:
  - enum `adaptor_state_t` (IDLE, RD_BURST, WR_BURST, DONE);
  - constants `BURST_BEATS`=4 and `BEAT_WIDTH`=64.
- One sub-module: `line_beat_buffer`.
  - 256-bit register, parallel-load from `pmem_wdata`, per-beat write from `bmem_rdata` at index cnt, per-beat read mux for `bmem_wdata`.
  - The FSM and counter stay in the top module.

## Test plan
- Read burst:
  - Stimulus: `pmem_read`, addr 0x0000_1040; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resps.
  - Required: one `pmem_resp` pulse with `pmem_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; `bmem_address`=0x0000_1040; 6 cycles total.
- Write burst:
  - Stimulus: `pmem_write`, `pmem_wdata` = {0xDD.., 0xCC.., 0xBB.., 0xAA..}.
  - Required: `bmem_wdata` sequence 0xAA.., 0xBB.., 0xCC.., 0xDD.. on successive resps, then one `pmem_resp`.
- Gapped resps:
  - Stimulus: read with 2 idle cycles between each beat.
  - Required: correct line assembly and `pmem_resp` exactly one cycle after the 4th beat.
- Simultaneous read and write:
  - Stimulus: both asserted together.
  - Required: write burst first; after DONE, if read is still held, a read burst follows; exactly 2 `pmem_resp` pulses in total.
- Reset mid-burst:
  - Stimulus: `rst_n`=0 after 2 read beats.
  - Required: all outputs 0 next cycle, no `pmem_resp`; a fresh read afterward completes normally with cnt starting at 0.
- Alignment:
  - Stimulus: addr 0x0000_105C.
  - Required: with `CACHELINE_ALIGN_EN`, `bmem_address`=0x0000_1040; without it, 0x0000_105C.
